// File: rtl/prio_seg_display_if.sv
// Encoder-sample inputs and multiplexed 7-segment outputs of prio_seg_display.
interface prio_seg_display_if;
   logic [2:0] enc_y;
   logic       enc_l;
   logic       hold;
   logic [7:0] seg_n;
   logic [3:0] an_n;
   logic [7:0] chg_cnt;

   modport master (output enc_y, enc_l, hold, input seg_n, an_n, chg_cnt);
   modport slave  (input enc_y, enc_l, hold, output seg_n, an_n, chg_cnt);
endinterface

// File: rtl/prio_seg_display.sv
// Samples priority-encoder index/valid, counts changes, and scans a 4-digit active-low 7-segment display.
// Optional whole-display blink while no input is valid: define PRIO_DISP_BLINK_EN.
//
// state | meaning
// D0    | digit 0 selected: encoder index, or '-' when not valid
// D1    | digit 1 selected: valid flag '1'/'0'
// D2    | digit 2 selected: change count low nibble
// D3    | digit 3 selected: change count high nibble
module prio_seg_display #(
   parameter int SCAN_DIV   = 1000,
   parameter int BLINK_LOG2 = 6
) (
   input logic               clk,
   input logic               rst_n,
   prio_seg_display_if.slave disp_if
);
   typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} dig_t;

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   dig_t        dig_q, dig_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  cap_y_q, cap_y_d;
   logic        cap_l_q, cap_l_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;
   logic        div_last;
   logic        blank;

   function automatic logic [7:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

   assign div_last = (div_q == DIV_LAST);

`ifdef PRIO_DISP_BLINK_EN
   logic [BLINK_LOG2:0] frame_q, frame_d;

   always_comb begin
      frame_d = frame_q;
      if (div_last && (dig_q == D3))
         frame_d = frame_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_q <= '0;
      else        frame_q <= frame_d;
   end

   assign blank = !cap_l_q && frame_q[BLINK_LOG2];
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_q   <= D0;
         div_q   <= '0;
         cap_y_q <= '0;
         cap_l_q <= 1'b0;
         cnt_q   <= '0;
         seg_q   <= 8'hFF;
         an_q    <= 4'hF;
      end else begin
         dig_q   <= dig_d;
         div_q   <= div_d;
         cap_y_q <= cap_y_d;
         cap_l_q <= cap_l_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   always_comb begin
      dig_d = dig_q;
      div_d = div_q + 16'd1;
      if (div_last) begin
         div_d = '0;
         case (dig_q)
            D0:      dig_d = D1;
            D1:      dig_d = D2;
            D2:      dig_d = D3;
            default: dig_d = D0;
         endcase
      end
   end

   // A drop of valid never counts; a rise of valid counts even with the same index.
   always_comb begin
      cap_y_d = cap_y_q;
      cap_l_d = cap_l_q;
      cnt_d   = cnt_q;
      if (!disp_if.hold) begin
         cap_y_d = disp_if.enc_y;
         cap_l_d = disp_if.enc_l;
         if (disp_if.enc_l && ({disp_if.enc_y, disp_if.enc_l} != {cap_y_q, cap_l_q}))
            cnt_d = cnt_q + 8'd1;
      end
   end

   // Anode and segments come from the same dig_q so they always switch together.
   always_comb begin
      an_d = ~(4'b0001 << dig_q);
      case (dig_q)
         D0:      seg_d = cap_l_q ? hex7({1'b0, cap_y_q}) : 8'hBF;
         D1:      seg_d = cap_l_q ? 8'hF9 : 8'hC0;
         D2:      seg_d = hex7(cnt_q[3:0]);
         default: seg_d = hex7(cnt_q[7:4]);
      endcase
      if (blank) begin
         an_d  = 4'hF;
         seg_d = 8'hFF;
      end
   end

   assign disp_if.seg_n   = seg_q;
   assign disp_if.an_n    = an_q;
   assign disp_if.chg_cnt = cnt_q;
endmodule

// File: tb/tb_prio_seg_display.sv
// Bench for prio_seg_display: per-cycle scoreboard of expected outputs plus directed display/count checks.
module tb_prio_seg_display;
   localparam int SCAN_DIV   = 4;
   localparam int BLINK_LOG2 = 1;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] seg;
      logic [7:0] cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   sb_on    = 0;
   exp_t sb_q[$];

   logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   prio_seg_display_if disp_if ();

   prio_seg_display #(.SCAN_DIV(SCAN_DIV), .BLINK_LOG2(BLINK_LOG2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .disp_if (disp_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: pushes the outputs expected after every edge (or reset assertion).
   int         m_div, m_dig, m_frame;
   logic [2:0] m_cap_y;
   logic       m_cap_l;
   logic [7:0] m_cnt;
   exp_t       m_e;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_div = 0; m_dig = 0; m_frame = 0;
         m_cap_y = 3'd0; m_cap_l = 1'b0; m_cnt = 8'd0;
         sb_q.delete();
         sb_q.push_back('{an: 4'hF, seg: 8'hFF, cnt: 8'h00});
      end else begin
         m_e.an = 4'hF;
         m_e.an[m_dig] = 1'b0;
         case (m_dig)
            0:       m_e.seg = m_cap_l ? hex_tab[m_cap_y] : 8'hBF;
            1:       m_e.seg = m_cap_l ? 8'hF9 : 8'hC0;
            2:       m_e.seg = hex_tab[m_cnt[3:0]];
            default: m_e.seg = hex_tab[m_cnt[7:4]];
         endcase
`ifdef PRIO_DISP_BLINK_EN
         if (!m_cap_l && ((m_frame >> BLINK_LOG2) & 1) == 1) begin
            m_e.an  = 4'hF;
            m_e.seg = 8'hFF;
         end
`endif
         if (!disp_if.hold) begin
            if (disp_if.enc_l && (disp_if.enc_y != m_cap_y || !m_cap_l))
               m_cnt = m_cnt + 8'd1;
            m_cap_y = disp_if.enc_y;
            m_cap_l = disp_if.enc_l;
         end
         if (m_div == SCAN_DIV - 1) begin
            m_div = 0;
            if (m_dig == 3) m_frame = (m_frame + 1) % (2 << BLINK_LOG2);
            m_dig = (m_dig + 1) % 4;
         end else begin
            m_div = m_div + 1;
         end
         m_e.cnt = m_cnt;
         sb_q.push_back(m_e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb_on) begin
         chk("sb_avail", (sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_an_n", disp_if.an_n, e.an);
            chk("sb_seg_n", disp_if.seg_n, e.seg);
            chk("sb_chg_cnt", disp_if.chg_cnt, e.cnt);
         end
      end
   end

   // Returns at the negedge where digit d has just become selected again.
   task automatic wait_digit(input int d, input string tag);
      logic [3:0] tgt;
      bit seen_other = 0;
      bit found = 0;
      tgt = ~(4'b0001 << d);
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (disp_if.an_n != tgt) seen_other = 1;
         else if (seen_other)     found = 1;
      end
      chk({tag, "_reach"}, found, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] an_exp;
      int dark;
      rst_n = 1'b0;
      disp_if.enc_y = 3'd0;
      disp_if.enc_l = 1'b0;
      disp_if.hold  = 1'b0;

      // 1: reset state, then D0 first after release, 4 clocks per digit
      @(posedge clk); #1 sb_on = 1;
      @(negedge clk);
      chk("t1_rst_seg", disp_if.seg_n, 8'hFF);
      chk("t1_rst_an", disp_if.an_n, 4'hF);
      chk("t1_rst_cnt", disp_if.chg_cnt, 8'h00);
      @(posedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         an_exp = ~(4'b0001 << (i / 4));
         chk("t1_scan_an", disp_if.an_n, an_exp);
         if (i == 0) chk("t1_d0_dash", disp_if.seg_n, 8'hBF);
      end

      // 2: index 5 valid
      @(negedge clk);
      disp_if.enc_y = 3'd5;
      disp_if.enc_l = 1'b1;
      @(posedge clk); #1 chk("t2_cnt", disp_if.chg_cnt, 8'h01);
      wait_digit(0, "t2d0"); chk("t2_d0", disp_if.seg_n, 8'h92);
      wait_digit(1, "t2d1"); chk("t2_d1", disp_if.seg_n, 8'hF9);
      wait_digit(2, "t2d2"); chk("t2_d2", disp_if.seg_n, 8'hF9);
      wait_digit(3, "t2d3"); chk("t2_d3", disp_if.seg_n, 8'hC0);

      // 3: hold freezes capture and count
      @(negedge clk);
      disp_if.hold  = 1'b1;
      disp_if.enc_y = 3'd3;
      wait_digit(0, "t3d0");
      chk("t3_hold_seg", disp_if.seg_n, 8'h92);
      chk("t3_hold_cnt", disp_if.chg_cnt, 8'h01);
      @(negedge clk) disp_if.hold = 1'b0;
      @(posedge clk); #1 chk("t3_rel_cnt", disp_if.chg_cnt, 8'h02);
      wait_digit(0, "t3d0b"); chk("t3_rel_seg", disp_if.seg_n, 8'hB0);

      // 4: 256 changes wrap the counter; valid drop never counts; valid rise does
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         disp_if.enc_y = i[0] ? 3'd0 : 3'd7;
         if (i == 253) begin
            @(posedge clk); #1 chk("t4_wrap00", disp_if.chg_cnt, 8'h00);
         end
      end
      @(posedge clk); #1 chk("t4_after256", disp_if.chg_cnt, 8'h02);
      @(negedge clk) disp_if.enc_l = 1'b0;
      @(posedge clk); #1 chk("t4_l_drop", disp_if.chg_cnt, 8'h02);
      @(negedge clk) disp_if.enc_l = 1'b1;
      @(posedge clk); #1 chk("t4_l_rise", disp_if.chg_cnt, 8'h03);

      // 5: reset at D2 with div=2
      @(negedge clk) disp_if.enc_l = 1'b0;
      wait_digit(2, "t5d2");
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_an", disp_if.an_n, 4'hF);
      chk("t5_rst_seg", disp_if.seg_n, 8'hFF);
      chk("t5_rst_cnt", disp_if.chg_cnt, 8'h00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_rel_an", disp_if.an_n, 4'hE);
      chk("t5_rel_seg", disp_if.seg_n, 8'hBF);
      chk("t5_rel_cnt", disp_if.chg_cnt, 8'h00);

`ifdef PRIO_DISP_BLINK_EN
      // 6: invalid input blinks 2 frames lit / 2 dark; valid input is steady
      dark = 0;
      for (int i = 1; i < 64; i++) begin
         @(posedge clk); #1;
         if (disp_if.an_n == 4'hF) dark++;
      end
      chk("t6_dark_cycles", dark, 32);
      @(negedge clk) disp_if.enc_l = 1'b1;
      repeat (2) @(posedge clk);
      dark = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         if (disp_if.an_n == 4'hF) dark++;
      end
      chk("t6_steady", dark, 0);
`endif

      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
